// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared pieces for the MixColumns / InvMixColumns engine:
//   AES_POLY      - reduction constant of x^8+x^4+x^3+x+1 (low byte)
//   state_t       - engine FSM states IDLE / BUSY / DONE
//   xtime         - multiply a GF(2^8) element by {02}
//   gf_mul_const  - multiply by a small constant ({01,02,03,09,0b,0d,0e})
//   mix_coef      - matrix coefficient for a (column byte - output row) offset
//   byte_lsb      - LSB position of state byte (col,row) in FIPS-197 order
//   col_lsb       - LSB position of a 32-bit column in the 128-bit state
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1b;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    // Every coefficient used by (Inv)MixColumns fits in four bits, so the
    // product is a XOR of b, 2b, 4b and 8b selected by the constant's bits.
    function automatic logic [7:0] gf_mul_const(input logic [3:0] c, input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (c[0] ? b  : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
               (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
    endfunction

    // Both matrices are circulant: the coefficient only depends on
    // (input row - output row) mod 4.
    function automatic logic [3:0] mix_coef(input logic inv, input logic [1:0] d);
        logic [3:0] c;
        case ({inv, d})
            3'b000:  c = 4'h2;
            3'b001:  c = 4'h3;
            3'b010:  c = 4'h1;
            3'b011:  c = 4'h1;
            3'b100:  c = 4'he;
            3'b101:  c = 4'hb;
            3'b110:  c = 4'hd;
            default: c = 4'h9;
        endcase
        return c;
    endfunction

    function automatic int byte_lsb(input int col, input int row);
        return 120 - 32 * col - 8 * row;
    endfunction

    function automatic int col_lsb(input int col);
        return byte_lsb(col, 3);
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// ---------------------------------------------------------------------------
// mix_column_word
// Combinational transform of one 32-bit AES state column.
//   col_in  [31:0] - column, row 0 in bits [31:24]
//   inv            - 0: MixColumns, 1: InvMixColumns
//   col_out [31:0] - transformed column, same row order
// ---------------------------------------------------------------------------
module mix_column_word
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    input  logic        inv,
    output logic [31:0] col_out
);

    logic [7:0] w_acc;

    always_comb begin
        col_out = '0;
        w_acc   = 8'h00;
        for (int r = 0; r < 4; r++) begin
            w_acc = 8'h00;
            for (int k = 0; k < 4; k++) begin
                w_acc = w_acc ^ gf_mul_const(mix_coef(inv, 2'(k - r)), col_in[24 - 8 * k +: 8]);
            end
            col_out[24 - 8 * r +: 8] = w_acc;
        end
    end

endmodule

// File: rtl/mix_columns_engine.sv
// ---------------------------------------------------------------------------
// mix_columns_engine
// Multi-cycle AES MixColumns / InvMixColumns unit. A 128-bit state is taken
// in, COLS_PER_CYCLE columns are transformed per cycle, and the result is
// offered downstream. One block is in flight at a time.
//   clk, rst_n               - clock, asynchronous active-low reset
//   in_valid / in_ready      - input handshake
//   in_data [127:0], in_inv  - state (FIPS-197 byte order) and direction
//   out_valid / out_ready    - output handshake
//   out_data [127:0]         - transformed state, held until the next result
// ---------------------------------------------------------------------------
module mix_columns_engine
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int P  = COLS_PER_CYCLE;
    localparam int N  = (P > 0) ? 4 / P : 1;
    localparam int BW = (N > 1) ? $clog2(N) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(N - 1);

    if (P != 1 && P != 2 && P != 4) begin : g_bad_cols_per_cycle
        $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [127:0]     r_out_data;
    logic [BW-1:0]    r_beat;
    logic             r_inv;
    logic [127:0]     r_work;

    logic [P*32-1:0]  w_col_in;
    logic [P*32-1:0]  w_col_out;
    logic [127:0]     w_next;

    // Column c is handled on beat c/P by multiplier slot c%P.
    always_comb begin
        w_col_in = '0;
        for (int c = 0; c < 4; c++) begin
            if (r_beat == BW'(c / P)) begin
                w_col_in[32 * (c % P) +: 32] = r_work[col_lsb(c) +: 32];
            end
        end
    end

    for (genvar g = 0; g < P; g++) begin : g_col
        mix_column_word u_col (
            .col_in  (w_col_in[32 * g +: 32]),
            .inv     (r_inv),
            .col_out (w_col_out[32 * g +: 32])
        );
    end

    // Working state with this beat's columns replaced; on the last beat this
    // is the complete result.
    always_comb begin
        w_next = r_work;
        for (int c = 0; c < 4; c++) begin
            if (r_beat == BW'(c / P)) begin
                w_next[col_lsb(c) +: 32] = w_col_out[32 * (c % P) +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_beat      <= '0;
            r_inv       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_inv      <= in_inv;
                        r_beat     <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (r_beat == LAST_BEAT) begin
                        r_beat      <= '0;
                        r_out_data  <= w_next;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_beat <= r_beat + BW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // The working register is pure data and needs no reset.
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && in_valid) begin
            r_work <= in_data;
        end else if (r_state == ST_BUSY) begin
            r_work <= w_next;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

endmodule

// File: tb/tb_mix_columns_engine.sv
// ---------------------------------------------------------------------------
// tb_mix_columns_engine
// Drives three engines (COLS_PER_CYCLE = 1, 2, 4) side by side. Expected
// results are queued per engine when a block is issued; a monitor pops and
// compares whenever an engine completes an output handshake.
// ---------------------------------------------------------------------------
module tb_mix_columns_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [2:0]   in_valid;
    logic [2:0]   in_ready;
    logic [2:0]   in_inv;
    logic [2:0]   out_valid;
    logic [2:0]   out_ready;
    logic [127:0] in_data  [3];
    logic [127:0] out_data [3];

    int compared   = 0;
    int mismatched = 0;
    bit rnd_done   = 1'b0;

    logic [127:0] q0[$];
    logic [127:0] q1[$];
    logic [127:0] q2[$];

    mix_columns_engine #(.COLS_PER_CYCLE(1)) u_p1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_inv(in_inv[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0])
    );
    mix_columns_engine #(.COLS_PER_CYCLE(2)) u_p2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_inv(in_inv[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1])
    );
    mix_columns_engine #(.COLS_PER_CYCLE(4)) u_p4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]), .in_inv(in_inv[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2])
    );

    // ---------------- reference model (plain GF(2^8) arithmetic) ----------
    function automatic logic [7:0] gmul(input logic [7:0] a, input int m);
        int r;
        int x;
        r = 0;
        x = int'(a);
        for (int b = 0; b < 8; b++) begin
            if (((m >> b) & 1) != 0) r = r ^ x;
            x = x << 1;
            if ((x & 'h100) != 0) x = x ^ 'h11b;
        end
        return 8'(r);
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
        int base[4];
        int acc;
        logic [127:0] o;
        if (inv) base = '{14, 11, 13, 9};
        else     base = '{2, 3, 1, 1};
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 0;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ int'(gmul(s[127 - 8 * (4 * c + k) -: 8], base[(k - r + 4) % 4]));
                o[127 - 8 * (4 * c + r) -: 8] = 8'(acc);
            end
        end
        return o;
    endfunction

    function automatic int lat_of(input int i);
        return 4 >> i;
    endfunction

    // ---------------- scoreboard helpers ----------------------------------
    task automatic push(input int i, input logic [127:0] v);
        case (i)
            0:       q0.push_back(v);
            1:       q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    function automatic int qsize(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic pop(input int i, output logic [127:0] v);
        case (i)
            0:       v = q0.pop_front();
            1:       v = q1.pop_front();
            default: v = q2.pop_front();
        endcase
    endtask

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %032h required %032h", nm, act, exp);
        end
    endtask

    // ---------------- monitor ----------------------------------------------
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst_n === 1'b1 && out_valid[i] === 1'b1 && out_ready[i] === 1'b1) begin
                if (qsize(i) == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_out_p%0d: got %032h required no output", lat_of(i), out_data[i]);
                end else begin
                    logic [127:0] e;
                    pop(i, e);
                    check($sformatf("out_data_n%0d", lat_of(i)), out_data[i], e);
                end
            end
        end
    end

    // ---------------- stimulus ---------------------------------------------
    // Issue one block, then scramble in_data/in_inv while the engine works.
    // Returns once out_valid is seen (or the bound expires).
    task automatic send(input int i, input logic [127:0] d, input logic inv, input logic [127:0] exp);
        int w;
        int lat;
        w = 0;
        while (in_ready[i] !== 1'b1 && w < 500) begin
            @(posedge clk); #1; w++;
        end
        if (in_ready[i] !== 1'b1) begin
            compared++;
            mismatched++;
            $display("FAIL in_ready_timeout_n%0d: got 0 required 1", lat_of(i));
        end
        push(i, exp);
        in_valid[i] = 1'b1;
        in_data[i]  = d;
        in_inv[i]   = inv;
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
        lat = 0;
        while (out_valid[i] !== 1'b1 && lat < 50) begin
            check($sformatf("in_ready_busy_n%0d", lat_of(i)), 128'(in_ready[i]), 128'(0));
            in_data[i] = {$urandom, $urandom, $urandom, $urandom};
            in_inv[i]  = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("latency_n%0d", lat_of(i)), 128'(lat), 128'(lat_of(i)));
    endtask

    task automatic run_rand(input int i, input int n);
        logic [127:0] x;
        logic inv;
        for (int k = 0; k < n; k++) begin
            x   = {$urandom, $urandom, $urandom, $urandom};
            inv = 1'($urandom_range(0, 1));
            send(i, x, inv, model(x, inv));
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog expired");
    end

    localparam logic [127:0] V_PLAIN = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] V_MIXED = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] V_FIPS_I = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] V_FIPS_O = 128'h046681e5_e0cb199a_48f8d37a_2806264c;

    initial begin
        logic [127:0] x;
        logic [127:0] y;
        logic [127:0] held;
        int w;

        rst_n     = 1'b0;
        in_valid  = '0;
        in_inv    = '0;
        out_ready = 3'b111;
        for (int i = 0; i < 3; i++) in_data[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_in_ready_n%0d", lat_of(i)), 128'(in_ready[i]), 128'(1));
            check($sformatf("reset_out_valid_n%0d", lat_of(i)), 128'(out_valid[i]), 128'(0));
            check($sformatf("reset_out_data_n%0d", lat_of(i)), out_data[i], 128'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Known-answer vectors
        send(0, V_PLAIN, 1'b0, V_MIXED);
        send(2, V_FIPS_I, 1'b0, V_FIPS_O);
        send(1, V_MIXED, 1'b1, V_PLAIN);
        repeat (3) @(posedge clk); #1;

        // Back-pressure: result must hold while out_ready is low
        out_ready[0] = 1'b0;
        x = {$urandom, $urandom, $urandom, $urandom};
        send(0, x, 1'b0, model(x, 1'b0));
        held = out_data[0];
        repeat (10) begin
            @(posedge clk); #1;
            check("stall_out_valid", 128'(out_valid[0]), 128'(1));
            check("stall_out_data", out_data[0], held);
            check("stall_in_ready", 128'(in_ready[0]), 128'(0));
        end
        out_ready[0] = 1'b1;
        repeat (3) @(posedge clk); #1;

        // Forward then inverse through the engines returns the original
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 3; k++) begin
                x = {$urandom, $urandom, $urandom, $urandom};
                send(i, x, 1'b0, model(x, 1'b0));
                y = out_data[i];
                send(i, y, 1'b1, x);
            end
        end
        repeat (3) @(posedge clk); #1;

        // Asynchronous reset during BUSY beat 1 of the P=1 engine
        w = 0;
        while (in_ready[0] !== 1'b1 && w < 50) begin
            @(posedge clk); #1; w++;
        end
        in_valid[0] = 1'b1;
        in_data[0]  = {$urandom, $urandom, $urandom, $urandom};
        in_inv[0]   = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("abort_in_ready_n%0d", lat_of(i)), 128'(in_ready[i]), 128'(1));
            check($sformatf("abort_out_valid_n%0d", lat_of(i)), 128'(out_valid[i]), 128'(0));
            check($sformatf("abort_out_data_n%0d", lat_of(i)), out_data[i], 128'(0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(0, V_PLAIN, 1'b0, V_MIXED);
        repeat (3) @(posedge clk); #1;

        // Randomised traffic with downstream stalls on all three engines
        fork
            begin
                fork
                    run_rand(0, 1000);
                    run_rand(1, 1000);
                    run_rand(2, 1000);
                join
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = 3'($urandom);
                end
            end
        join
        out_ready = 3'b111;

        w = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && w < 200) begin
            @(posedge clk); #1; w++;
        end
        check("drain_pending", 128'(q0.size() + q1.size() + q2.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mix_columns_engine.md
# mix_columns_engine

Parametrised AES MixColumns / InvMixColumns unit with a valid/ready handshake on both sides. It processes a 128-bit state over 4/COLS_PER_CYCLE cycles, using COLS_PER_CYCLE column multipliers. The unit selects forward or inverse per block, which lets one instance serve both the encrypt and decrypt round datapaths. It sits between the ShiftRows and AddRoundKey stages of the round pipeline.

## Interface
- COLS_PER_CYCLE, 1, columns transformed per cycle; legal values are 1, 2 and 4, and any other value is an elaboration error
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input block present
- in_ready  out  1  unit can accept a block
- in_data  in  128  state; byte k at [127-8k -: 8] (FIPS-197 order), column c = bytes 4c..4c+3, byte 4c = row 0
- in_inv  in  1  0 = MixColumns, 1 = InvMixColumns; sampled with in_data
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- out_data  out  128  transformed state, same byte order

## Operation
- Reset is asynchronous and active-low, on one clock. The unit enters IDLE with in_ready=1, out_valid=0, out_data=0, beat counter 0 and the mode register 0.
- There are three FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch in_data into the working register and in_inv into the mode register, clear the beat counter, then go to BUSY.
  - BUSY: in_ready=0. Each cycle, replace columns beat*P .. beat*P+P-1 of the working register with their transform, then increment beat. On the final beat (beat = N-1, where N = 4/P), the full result is written to out_data and the state goes to DONE.
  - DONE: out_valid=1 and out_data is stable. On out_ready, clear out_valid and go to IDLE. out_data holds its value until the next result is written.
- The unit never overlaps blocks: in_ready is 0 in BUSY and DONE. in_ready is a pure function of state, with no combinational path from out_ready.
- The column transform uses GF(2^8) arithmetic modulo x^8+x^4+x^3+x+1.
  - Forward rows: {02 03 01 01}, {01 02 03 01}, {01 01 02 03}, {03 01 01 02}.
  - Inverse rows: {0e 0b 0d 09}, {09 0e 0b 0d}, {0d 09 0e 0b}, {0b 0d 09 0e}.
  - All products are reduced to 8 bits. Integer multiply is forbidden; multiplication is built from xtime chains and XOR.
- Beat counter width is max(1, clog2(N)). The counter returns to 0 after the final beat.
- in_data and in_inv are ignored outside the IDLE accept cycle. Changes to them during BUSY have no effect.
- out_ready while out_valid=0 has no effect.
- rst_n asserted mid-BUSY or mid-DONE aborts the block. All outputs return to their reset values immediately, and the result is discarded.

## Timing
- Latency is N cycles from the accept edge to out_valid high: P=4 gives 1 cycle, P=2 gives 2, P=1 gives 4.
- Peak throughput is one block per N+2 cycles with out_ready held high: accept, N compute cycles, then one DONE/handshake cycle.
- All outputs are registered.
- The critical path is one inverse column (xtime^3 plus an XOR tree) behind a P-way column mux.

## Structure
- aes_pkg holds the shared pieces:
  - the xtime function
  - the gf_mul_const function for {01,02,03,09,0b,0d,0e}
  - the AES_POLY constant (8'h1b)
  - the state enum for IDLE/BUSY/DONE
  - a byte/column index helper for the FIPS-197 ordering
- Sub-module mix_column_word transforms one 32-bit column combinationally, with ports col_in[31:0], inv, col_out[31:0]. The engine instantiates it COLS_PER_CYCLE times.

## Test plan
- P=1, forward. in_data = db135345_f20a225c_01010101_2d26314c → out_data = 8e4da1bc_9fdc589d_01010101_4d7ebdf8, with out_valid exactly 4 cycles after the accept edge.
- P=4, forward, FIPS-197 App. B round 1. in_data = d4bf5d30_e0b452ae_b84111f1_1e2798e5 → 046681e5_e0cb199a_48f8d37a_2806264c, with 1-cycle latency.
- P=2, inverse. Feed 8e4da1bc_9fdc589d_01010101_4d7ebdf8 with in_inv=1 → db135345_f20a225c_01010101_2d26314c. Also check the 2-cycle latency and that in_ready=0 throughout.
- Back-pressure:
  - Hold out_ready=0 for 10 cycles in DONE. out_valid and out_data must stay stable, and in_ready=0.
  - Toggle in_data and in_inv during BUSY. The result must be unaffected.
- Reset mid-operation: drop rst_n asynchronously during BUSY beat 1 (P=1). All outputs must return to 0 and in_ready to 1 without waiting for a clock edge. A new block after release must produce the correct result.
- Randomised, all P values: 1000 blocks with random in_inv and random out_ready stalls, checked against a reference model. Also check that forward followed by inverse returns the original state.
